muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Multicycle sequencer for the HI/LO multiply/divide resource of the pipelined MIPS core.
//  - Accepts mult/div requests from the Execute stage and runs a fixed-latency multiply or a
//    32-iteration signed restoring divide.
//  - Owns the HI/LO registers and raises a stall to the hazard unit while a new request or a
//    HI/LO read would collide with an operation in flight.
// PARAMETERS
//  WIDTH    32  operand/HI/LO width; divide iterations = WIDTH
//  MUL_LAT  2   multiply cycles in MUL state, >=1 (MUL_LAT-1 internal product pipeline regs)
// PORTS
//  clk      in   1      core clock
//  reset    in   1      synchronous, active-high
//  multE    in   1      signed multiply request, Execute stage
//  divE     in   1      signed divide request, Execute stage
//  flushE   in   1      Execute flush; suppresses a start in the same cycle
//  rdreqD   in   1      movlo/movhi in Decode wants HI/LO
//  srcaE    in   WIDTH  rs operand (multiplicand / dividend)
//  srcbE    in   WIDTH  rt operand (multiplier / divisor)
//  hi       out  WIDTH  HI register (product[63:32] / remainder)
//  lo       out  WIDTH  LO register (product[31:0] / quotient)
//  busy     out  1      state != IDLE
//  stallMD  out  1      busy & (multE | divE | rdreqD); to hazard unit
// BEHAVIOUR
//  - Reset: state=IDLE; hi=lo=0; busy=stallMD=0; counter and operand regs cleared.
//    Reset mid-operation aborts the op and leaves HI/LO at 0.
//  - start = (multE|divE) & ~flushE & ~busy. If multE and divE are both high, mult wins.
//    Operands are captured on the start edge.
//  - States: IDLE -> MUL (mult start) | DIV (div start)
//    MUL -> IDLE after MUL_LAT cycles; DIV -> FIX after WIDTH cycles; FIX -> IDLE after 1 cycle.
//  - Timing: start sampled in cycle 0.
//    Mult: busy high cycles 1..MUL_LAT; new HI/LO visible from cycle MUL_LAT+1.
//    Div: busy high cycles 1..WIDTH+1; new HI/LO visible from cycle WIDTH+2 (34 by default).
//  - HI/LO are written only on the edge leaving MUL or FIX; they hold otherwise.
//  - Mult: full signed 2*WIDTH product; {hi,lo} = srca*srcb.
//  - Div: DIV iterates on magnitudes, one quotient bit per cycle, MSB first, using div_step.
//    FIX applies signs: quotient negated if operand signs differ; remainder takes the sign of
//    the dividend (truncating division).
//  - Div boundaries:
//    divisor==0: lo=all-ones, hi=srca; timing unchanged.
//    -2^(W-1) / -1: lo=32'h8000_0000, hi=0.
//  - stallMD is combinational, asserted while busy whenever a new mult/div is in E or a HI/LO
//    read is in D. A request held by the stall starts on the first cycle busy is low.
//  - Requests arriving while busy are never queued or dropped silently; they are held by the
//    stall.
//  - flushE with busy high does not abort the op in flight; only the new request is squashed.
// STRUCTURE
//  - Shared package md_pkg: typedef enum {IDLE,MUL,DIV,FIX} md_state_t; constants WIDTH and
//    DIV_CNT_W = $clog2(WIDTH)+1.
//  - One sub-module div_step: combinational restoring iteration.
//    (rem_in, quo_in, divisor) -> (rem_out, quo_out).
//    Parent holds the counter, state register, multiply pipeline and sign fixup.
// TESTING
//  - mult srca=7, srcb=-3 -> after MUL_LAT+1 cycles hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
//    busy high exactly MUL_LAT cycles.
//  - div srca=-17, srcb=5 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFE (-2).
//    busy high 33 cycles; HI/LO unchanged until cycle 34.
//  - div srcb=0, srca=32'h1234 -> lo=32'hFFFF_FFFF, hi=32'h1234.
//    div 32'h8000_0000 / -1 -> lo=32'h8000_0000, hi=0.
//  - Start div, then rdreqD=1 at cycle 5 -> stallMD=1 cycles 5..33, 0 at 34; HI/LO valid at 34.
//    Back-to-back divE held by stall starts at cycle 34.
//  - multE=1 with flushE=1 -> no start, busy stays 0, HI/LO unchanged.
//    multE=divE=1 -> multiply performed.
//  - reset asserted at cycle 10 of a div -> next cycle busy=0, hi=lo=0.
//    A fresh mult then completes normally.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package md_pkg;

  localparam int WIDTH     = 32;
  localparam int DIV_CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep the difference if non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // quo_in holds the unconsumed dividend bits in its top and accumulated
  // quotient bits in its bottom, so one register serves both roles.
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      rem_out = diff[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = shifted[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// HI/LO multiply/divide sequencer: fixed-latency signed multiply, WIDTH-cycle
// signed restoring divide with a sign-fixup cycle, and the HI/LO stall logic.
module muldiv_seq #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multE,
  input  logic             divE,
  input  logic             flushE,
  input  logic             rdreqD,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stallMD
);

  import md_pkg::*;

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  md_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   srca_q, srca_d;
  logic [WIDTH-1:0]   srcb_q, srcb_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               start;
  logic [WIDTH-1:0]   step_rem, step_quo;
  logic signed [2*WIDTH-1:0] prod_now;
  logic signed [2*WIDTH-1:0] prod_final;

  assign busy    = (state_q != IDLE);
  assign stallMD = busy & (multE | divE | rdreqD);
  assign start   = (multE | divE) & ~flushE & ~busy;
  assign hi      = hi_q;
  assign lo      = lo_q;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  assign prod_now = $signed(srca_q) * $signed(srcb_q);

  // Operands are stable for the whole MUL state, so the pipeline just
  // retimes the product; its last stage is valid on the final MUL cycle.
  generate
    if (MUL_LAT > 1) begin : g_pipe
      logic signed [2*WIDTH-1:0] pipe_q [MUL_LAT-1];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < MUL_LAT-1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= prod_now;
          for (int i = 1; i < MUL_LAT-1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign prod_final = pipe_q[MUL_LAT-2];
    end else begin : g_nopipe
      assign prod_final = prod_now;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    srca_d  = srca_q;
    srcb_d  = srcb_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          srca_d = srcaE;
          srcb_d = srcbE;
          cnt_d  = '0;
          if (multE) begin
            state_d = MUL;
          end else begin
            state_d = DIV;
            rem_d   = '0;
            quo_d   = srcaE[WIDTH-1] ? -srcaE : srcaE;
            dvs_d   = srcbE[WIDTH-1] ? -srcbE : srcbE;
          end
        end
      end
      MUL: begin
        if (cnt_q == CNT_W'(MUL_LAT-1)) begin
          state_d      = IDLE;
          cnt_d        = '0;
          {hi_d, lo_d} = prod_final;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DIV: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (srcb_q == '0) begin
          lo_d = '1;
          hi_d = srca_q;
        end else begin
          lo_d = (srca_q[WIDTH-1] ^ srcb_q[WIDTH-1]) ? -quo_q : quo_q;
          hi_d = srca_q[WIDTH-1] ? -rem_q : rem_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      srca_q  <= '0;
      srcb_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: a latency/arithmetic model checked every
// cycle, plus hand-computed literal results for the key vectors.
module tb_muldiv_seq;

  localparam int W  = 32;
  localparam int ML = 2;

  logic         clk = 1'b0;
  logic         reset, multE, divE, flushE, rdreqD;
  logic [W-1:0] srcaE, srcbE, hi, lo;
  logic         busy, stallMD;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  muldiv_seq #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk     (clk),
    .reset   (reset),
    .multE   (multE),
    .divE    (divE),
    .flushE  (flushE),
    .rdreqD  (rdreqD),
    .srcaE   (srcaE),
    .srcbE   (srcbE),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .stallMD (stallMD)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: an op occupies a fixed number of cycles, then its arithmetic
  // result lands in HI/LO.
  int           exp_cnt = 0;
  logic [W-1:0] exp_hi, exp_lo, pend_hi, pend_lo;
  bit           model_on = 0;

  always @(posedge clk) begin
    longint a, b, q, r, p;
    if (reset) begin
      exp_cnt = 0; exp_hi = '0; exp_lo = '0; model_on = 1;
    end else if (exp_cnt > 0) begin
      exp_cnt--;
      if (exp_cnt == 0) begin
        exp_hi = pend_hi; exp_lo = pend_lo;
      end
    end else if ((multE || divE) && !flushE) begin
      a = longint'($signed(srcaE));
      b = longint'($signed(srcbE));
      if (multE) begin
        p = a * b;
        pend_hi = p[63:32]; pend_lo = p[31:0];
        exp_cnt = ML;
      end else begin
        if (b == 0) begin
          pend_lo = '1; pend_hi = srcaE;
        end else begin
          q = a / b; r = a % b;
          pend_lo = q[31:0]; pend_hi = r[31:0];
        end
        exp_cnt = W + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("busy",    {31'b0, busy},    {31'b0, exp_cnt > 0});
      chk("stallMD", {31'b0, stallMD}, {31'b0, (exp_cnt > 0) && (multE || divE || rdreqD)});
      chk("hi", hi, exp_hi);
      chk("lo", lo, exp_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b);
    multE = m; divE = d; srcaE = a; srcbE = b;
    tick();
    multE = 0; divE = 0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    if (n >= 100) chk("timeout_busy", {31'b0, busy}, 32'h0);
  endtask

  task automatic report(input string what, input logic [W-1:0] a, input logic [W-1:0] b);
    $display("txn %s a=%h b=%h -> hi=%h lo=%h (cycle %0d)", what, a, b, hi, lo, cyc);
  endtask

  int n;

  initial begin
    reset = 1; multE = 0; divE = 0; flushE = 0; rdreqD = 0; srcaE = '0; srcbE = '0;
    repeat (3) tick();
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    reset = 0;
    tick();

    issue(1, 0, 32'd7, -32'sd3);
    wait_idle(n);
    chk("mul_busy_cycles", n, ML);
    chk("mul_hi", hi, 32'hFFFF_FFFF);
    chk("mul_lo", lo, 32'hFFFF_FFEB);
    report("mult", 32'd7, -32'sd3);

    issue(0, 1, -32'sd17, 32'd5);
    wait_idle(n);
    chk("div_busy_cycles", n, W + 1);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFE);
    report("div", -32'sd17, 32'd5);

    issue(0, 1, 32'h1234, 32'h0);
    wait_idle(n);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'h1234);
    report("div", 32'h1234, 32'h0);

    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);
    report("div", 32'h8000_0000, 32'hFFFF_FFFF);

    issue(0, 1, 32'd17, -32'sd5);
    wait_idle(n);
    report("div", 32'd17, -32'sd5);

    // Read request at cycle 5 of a divide, with a second divide held behind it.
    issue(0, 1, 32'd1000, 32'd3);
    repeat (4) tick();
    rdreqD = 1; divE = 1; srcaE = 32'd100; srcbE = -32'sd7;
    wait_idle(n);
    chk("stall_span", n, 29);
    chk("stall_end", {31'b0, stallMD}, 32'h0);
    chk("rd_hi", hi, 32'd1);
    chk("rd_lo", lo, 32'd333);
    report("div", 32'd1000, 32'd3);
    tick();
    rdreqD = 0; divE = 0;
    chk("b2b_busy", {31'b0, busy}, 32'h1);
    wait_idle(n);
    chk("b2b_busy_cycles", n, W + 1);
    chk("b2b_hi", hi, 32'd2);
    chk("b2b_lo", lo, 32'hFFFF_FFF2);
    report("div", 32'd100, -32'sd7);

    multE = 1; flushE = 1; srcaE = 32'd9; srcbE = 32'd9;
    tick();
    multE = 0; flushE = 0;
    chk("flush_busy", {31'b0, busy}, 32'h0);
    chk("flush_lo", lo, 32'hFFFF_FFF2);
    report("flushed", 32'd9, 32'd9);

    issue(1, 1, -32'sd5, 32'd6);
    wait_idle(n);
    chk("both_busy_cycles", n, ML);
    chk("both_hi", hi, 32'hFFFF_FFFF);
    chk("both_lo", lo, 32'hFFFF_FFE2);
    report("mult+div", -32'sd5, 32'd6);

    // Flush arriving while busy only squashes the new request.
    issue(1, 0, 32'd3, 32'd4);
    multE = 1; flushE = 1; srcaE = 32'd50; srcbE = 32'd50;
    tick();
    multE = 0; flushE = 0;
    wait_idle(n);
    chk("flush_busy_lo", lo, 32'd12);
    chk("flush_busy_hi", hi, 32'd0);
    report("mult", 32'd3, 32'd4);

    issue(0, 1, -32'sd17, 32'd5);
    repeat (9) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    report("reset", -32'sd17, 32'd5);

    issue(1, 0, 32'd123456, -32'sd789);
    wait_idle(n);
    report("mult", 32'd123456, -32'sd789);
    issue(1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_idle(n);
    chk("maxmul_hi", hi, 32'h3FFF_FFFF);
    chk("maxmul_lo", lo, 32'h0000_0001);
    report("mult", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    issue(1, 0, 32'h8000_0000, 32'h8000_0000);
    wait_idle(n);
    report("mult", 32'h8000_0000, 32'h8000_0000);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
